// File: rtl/fp_regfile_sb.sv
// FP register file with N read / M write ports, optional write-to-read bypass
// and a per-register busy scoreboard for multi-cycle results.
module fp_rf_rd_port #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W:0]                    addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]    regs,
  input  logic [NUM_REGS-1:0]                busy,
  input  logic [NUM_WR-1:0]                  wb_en,
  input  logic [NUM_WR-1:0][ADDR_W:0]        wb_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]      wb_data,
  output logic [DATA_W-1:0]                  data,
  output logic                               busy_flag
);
  logic live;

  always_comb begin
    live = addr[ADDR_W] && !(ZERO_REG != 0 && addr[ADDR_W-1:0] == '0);
    data = live ? regs[addr[ADDR_W-1:0]] : '0;
    // ascending scan so the highest-index writer wins the forward
    for (int j = 0; j < NUM_WR; j++)
      if (BYPASS != 0 && live && wb_en[j] && wb_addr[j] == addr) data = wb_data[j];
    busy_flag = live && busy[addr[ADDR_W-1:0]];
  end
endmodule

module fp_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*(ADDR_W+1)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic                         stall,
  input  logic [NUM_WR-1:0]            wb_en,
  input  logic [NUM_WR*(ADDR_W+1)-1:0] wb_addr,
  input  logic [NUM_WR*DATA_W-1:0]     wb_data,
  input  logic                         iss_en,
  input  logic [ADDR_W:0]              iss_addr,
  input  logic                         flush,
  output logic [NUM_REGS-1:0]          busy_vec
);
  logic [NUM_RD-1:0][ADDR_W:0]       ra;
  logic [NUM_RD-1:0][DATA_W-1:0]     rdv;
  logic [NUM_WR-1:0][ADDR_W:0]       wa;
  logic [NUM_WR-1:0][DATA_W-1:0]     wd;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs, regs_nxt;
  logic [NUM_REGS-1:0]               busy, busy_nxt, wr_hit, iss_hit;

  assign ra       = rd_addr;
  assign wa       = wb_addr;
  assign wd       = wb_data;
  assign rd_data  = rdv;
  assign stall    = |rd_busy;
  assign busy_vec = busy;

  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    wr_hit   = '0;
    iss_hit  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ZERO_REG == 0 || r != 0) begin
        iss_hit[r] = iss_en && iss_addr[ADDR_W] && iss_addr[ADDR_W-1:0] == ADDR_W'(r);
        for (int j = 0; j < NUM_WR; j++)
          if (wb_en[j] && wa[j][ADDR_W] && wa[j][ADDR_W-1:0] == ADDR_W'(r)) begin
            wr_hit[r]   = 1'b1;
            regs_nxt[r] = wd[j];
          end
      end
      // issue beats writeback: the writeback belongs to an older op
      if (flush)           busy_nxt[r] = 1'b0;
      else if (iss_hit[r]) busy_nxt[r] = 1'b1;
      else if (wr_hit[r])  busy_nxt[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      regs <= regs_nxt;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    fp_rf_rd_port #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .addr(ra[k]), .regs(regs), .busy(busy),
      .wb_en(wb_en), .wb_addr(wa), .wb_data(wd),
      .data(rdv[k]), .busy_flag(rd_busy[k])
    );
  end
endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed bench for fp_regfile_sb: three builds (bypass, no bypass, zero reg)
// share one stimulus; expected values are hand-computed constants.
module tb_fp_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] rd_addr;
  logic [1:0]  wb_en;
  logic [11:0] wb_addr;
  logic [63:0] wb_data;
  logic        iss_en, flush;
  logic [5:0]  iss_addr;

  logic [95:0] rdd_b, rdd_n, rdd_z;
  logic [2:0]  rdb_b, rdb_n, rdb_z;
  logic        stl_b, stl_n, stl_z;
  logic [31:0] bv_b, bv_n, bv_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_regfile_sb #(.BYPASS(1), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(rdb_b),
    .stall(stl_b), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(bv_b));

  fp_regfile_sb #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd_n), .rd_busy(rdb_n),
    .stall(stl_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(bv_n));

  fp_regfile_sb #(.BYPASS(1), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd_z), .rd_busy(rdb_z),
    .stall(stl_z), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(bv_z));

  function automatic logic [5:0] fa(input int i);
    return {1'b1, 5'(i)};
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_en = '0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_all(input logic [5:0] a);
    rd_addr = {3{a}};
  endtask

  initial begin
    // reset with random activity on every input
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 18'($urandom); wb_en = 2'($urandom); wb_addr = 12'($urandom);
      wb_data = {$urandom, $urandom}; iss_en = 1'($urandom);
      iss_addr = 6'($urandom); flush = 1'($urandom);
      @(negedge clk);
    end
    idle();
    rd_all(fa(5));
    #1 rst = 1'b1;
    #1;
    chk("rst_data", rdd_b, 96'h0);
    chk("rst_busy", {29'h0, rdb_b}, 96'h0);
    chk("rst_bvec", {64'h0, bv_b}, 96'h0);
    chk("rst_stall", {95'h0, stl_b}, 96'h0);

    // write f5 then read on all ports
    tick();
    wb_en = 2'b01; wb_addr = {6'h0, fa(5)}; wb_data = {32'h0, 32'h3F80_0000};
    tick();
    idle();
    #1;
    chk("wr_f5", rdd_b, {3{32'h3F80_0000}});

    // two writers on f7, higher port wins
    wb_en = 2'b11; wb_addr = {fa(7), fa(7)}; wb_data = {32'h2222_2222, 32'h1111_1111};
    tick();
    idle();
    rd_all(fa(7));
    #1;
    chk("wr_prio", rdd_b, {3{32'h2222_2222}});
    chk("wr_prio_nb", rdd_n, {3{32'h2222_2222}});

    // bypass vs no bypass
    wb_en = 2'b10; wb_addr = {fa(9), 6'h0}; wb_data = {32'h4049_0FDB, 32'h0};
    rd_all(fa(9));
    #1;
    chk("byp_same", rdd_b[31:0], 96'h4049_0FDB);
    chk("nobyp_same", rdd_n[31:0], 96'h0);
    tick();
    idle();
    #1;
    chk("nobyp_next", rdd_n[31:0], 96'h4049_0FDB);

    // scoreboard: issue f3, busy for 10 cycles
    iss_en = 1'b1; iss_addr = fa(3);
    tick();
    idle();
    rd_all(fa(3));
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("sb_busy", {29'h0, rdb_b}, 96'h7);
      chk("sb_stall", {95'h0, stl_b}, 96'h1);
      tick();
    end
    wb_en = 2'b10; wb_addr = {fa(3), 6'h0}; wb_data = {32'h4000_0000, 32'h0};
    #1;
    chk("sb_wb_busy", {29'h0, rdb_b}, 96'h7);
    chk("sb_wb_byp", rdd_b[31:0], 96'h4000_0000);
    tick();
    idle();
    #1;
    chk("sb_clr_busy", {29'h0, rdb_b}, 96'h0);
    chk("sb_clr_stall", {95'h0, stl_b}, 96'h0);
    chk("sb_clr_data", rdd_b[31:0], 96'h4000_0000);

    // issue and writeback to f4 together: busy wins, data updates
    iss_en = 1'b1; iss_addr = fa(4);
    wb_en = 2'b01; wb_addr = {6'h0, fa(4)}; wb_data = {32'h0, 32'h0000_ABCD};
    tick();
    idle();
    rd_all(fa(4));
    #1;
    chk("iss_wb_bvec", {64'h0, bv_b}, 96'h10);
    chk("iss_wb_data", rdd_n[31:0], 96'h0000_ABCD);

    // flush discards same-cycle issue, write still lands
    flush = 1'b1; iss_en = 1'b1; iss_addr = fa(6);
    wb_en = 2'b01; wb_addr = {6'h0, fa(6)}; wb_data = {32'h0, 32'h0000_0055};
    tick();
    idle();
    rd_all(fa(6));
    #1;
    chk("flush_bvec", {64'h0, bv_b}, 96'h0);
    chk("flush_data", rdd_n[31:0], 96'h55);

    // MSB-clear address: reads zero, writes/issues ignored
    rd_all(6'b0_00101);
    #1;
    chk("inv_rd_data", rdd_b, 96'h0);
    chk("inv_rd_busy", {29'h0, rdb_b}, 96'h0);
    wb_en = 2'b01; wb_addr = {6'h0, 6'b0_00101}; wb_data = {32'h0, 32'hDEAD_BEEF};
    iss_en = 1'b1; iss_addr = 6'b0_00101;
    tick();
    idle();
    rd_all(fa(5));
    #1;
    chk("inv_wr", rdd_b[31:0], 96'h3F80_0000);
    chk("inv_iss", {64'h0, bv_b}, 96'h0);

    // register 0: hardwired in dut_z, ordinary elsewhere
    wb_en = 2'b01; wb_addr = {6'h0, fa(0)}; wb_data = {32'h0, 32'hFFFF_FFFF};
    rd_all(fa(0));
    #1;
    chk("z0_byp", rdd_z[31:0], 96'h0);
    tick();
    idle();
    #1;
    chk("z0_rd", rdd_z, 96'h0);
    chk("r0_rd", rdd_b[31:0], 96'hFFFF_FFFF);
    iss_en = 1'b1; iss_addr = fa(0);
    tick();
    idle();
    #1;
    chk("z0_iss", {95'h0, bv_z[0]}, 96'h0);
    chk("z0_rdbusy", {29'h0, rdb_z}, 96'h0);
    chk("r0_iss", {95'h0, bv_b[0]}, 96'h1);

    // async reset mid-cycle with busy_vec = 0x10
    iss_en = 1'b1; iss_addr = fa(4);
    wb_en = 2'b01; wb_addr = {6'h0, fa(0)}; wb_data = '0;
    tick();
    idle();
    rd_all(fa(5));
    #1;
    chk("pre_rst_bvec", {64'h0, bv_b}, 96'h10);
    #1 rst = 1'b0;
    #1;
    chk("async_bvec", {64'h0, bv_b}, 96'h0);
    chk("async_data", rdd_b, 96'h0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
Parametrised floating-point register file with an integrated scoreboard, successor to the single-write, two-read FP register file. Supports N read ports (3 for fused multiply-add), M writeback ports (single-cycle FPU lane plus multi-cycle div/sqrt lane), and optional write-to-read bypass. Per-register busy bits track in-flight multi-cycle results so decode can stall. Sits between decode (reads/issue) and the FP writeback stage.

Parameters:
DATA_W, 32, register data width.
NUM_REGS, 32, number of architectural registers; power of two.
ADDR_W, $clog2(NUM_REGS), index width. Every address bus is ADDR_W+1 wide; the MSB is the "FP operand valid" flag.
NUM_RD, 3, read ports.
NUM_WR, 2, write ports; higher index has higher priority.
ZERO_REG, 0, 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is an ordinary register.
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
rd_addr  in  NUM_RD*(ADDR_W+1)  packed read addresses; port k is bits [k*(ADDR_W+1) +: ADDR_W+1].
rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
rd_busy  out  NUM_RD  per-port busy flag of the addressed register.
stall  out  1  OR of rd_busy.
wb_en  in  NUM_WR  per-port write enable.
wb_addr  in  NUM_WR*(ADDR_W+1)  packed write addresses.
wb_data  in  NUM_WR*DATA_W  packed write data.
iss_en  in  1  issue of a multi-cycle op; marks its destination busy.
iss_addr  in  ADDR_W+1  destination of the issued op.
flush  in  1  synchronous clear of all busy bits; data is untouched.
busy_vec  out  NUM_REGS  raw scoreboard, for debug and verification.

Behaviour:
- Reset (rst=0, async): all registers go to 0 and all busy bits to 0. Consequences: rd_data=0, rd_busy=0, stall=0, busy_vec=0. Reset asserted mid-operation discards pending writes and busy state immediately.
- Address valid rule: a read, write or issue whose address MSB is 0 is ignored. Such a read returns 0 with rd_busy=0. A write or issue with MSB 0 changes no data and no busy bit.
- Read: combinational, zero latency. Data comes from the register array, or from bypass when BYPASS=1.
- Bypass: if any wb_en[j] targets the read index with valid MSB, rd_data is the wb_data of the highest-priority matching j. With BYPASS=0, the new value is visible from the next cycle.
- ZERO_REG=1, index 0: reads return 0; writes to index 0 are dropped; iss_en to index 0 is ignored; rd_busy is always 0.
- Write: the array updates on the rising clock edge. If several enabled ports target the same index, the highest-index port's data is stored.
- Scoreboard, per register, updated on the clock edge in this priority order:
  - flush: all busy bits become 0. A same-cycle iss_en is also discarded. Same-cycle writes still update data.
  - iss_en to index r: busy[r] becomes 1. This wins over a same-cycle writeback to r, because the writeback belongs to an older op.
  - valid writeback to r (any port): busy[r] becomes 0.
  - otherwise: hold.
- rd_busy[k] is busy[index] of the registered scoreboard only; it is not bypassed. A read in the same cycle as the clearing writeback sees busy=1. With BYPASS=1, decode may still consume the bypassed data.
- Writeback to a register that is not busy is legal: data updates and busy stays 0.
- No X on any output after reset, for any input combination.
- RTL is a plain flop array (no memory macro). Read muxes and bypass compares are generated loops over NUM_RD and NUM_WR.

Test Plan:
- Reset: drive rst=0 with all inputs random, then release. All rd_data=0, rd_busy=0, busy_vec=0. Assert rst=0 while busy_vec=0x0000_0010; busy_vec must go to 0 without a clock edge.
- Write/read and priority: write wb0 f5=0x3F80_0000. Next cycle read f5 on all 3 ports → 0x3F80_0000. Then in one cycle wb0 f7=0x1111_1111 and wb1 f7=0x2222_2222 → read f7 = 0x2222_2222.
- Bypass: BYPASS=1, wb1 f9=0x4049_0FDB and read f9 in the same cycle → rd_data=0x4049_0FDB. Rebuild with BYPASS=0 → old value that cycle, new value the next.
- Scoreboard: iss_en f3, then read f3 → rd_busy=1, stall=1 for 10 cycles. Then wb1 f3=0x4000_0000: same cycle rd_busy=1; next cycle rd_busy=0 and data=0x4000_0000.
- Simultaneous events: iss_en f4 plus wb0 f4 in one cycle → busy[4]=1 and data updated. flush plus iss_en f6 → busy_vec=0.
- Valid/zero rules: read address 6'b0_00101 → data 0, busy 0. ZERO_REG=1: write f0=0xFFFF_FFFF, then read f0 → 0; iss_en f0 → busy_vec[0]=0. ZERO_REG=0: the same write reads back 0xFFFF_FFFF.
